chart_writer: RTL and testbench
===============================

# chart_writer

Writable counterpart to the chart ROM: accepts a stream of chart words over a valid/ready handshake and writes them sequentially into an on-chip RAM. The game engine reads the same RAM through a synchronous read port. A start command clears the whole RAM before loading begins, so a short chart never inherits stale steps. Sits between the host byte/word source (UART receiver or test feeder) and the note scheduler.

## Interface
- width_p, default 8: chart word width in bits.
- depth_p, default 128: RAM depth in words; power of two, at least 2.
- clk_i  input  1  sole clock; all logic is on its rising edge.
- reset_i  input  1  synchronous, active-high reset.
- start_i  input  1  single-cycle pulse; begins clear-then-load from any state.
- valid_i  input  1  data_i/last_i hold a word.
- data_i  input  width_p  chart word.
- last_i  input  1  qualifies the final word of a chart; meaningful only when valid_i is high.
- ready_o  output  1  writer accepts a word this cycle.
- rd_addr_i  input  $clog2(depth_p)  game-side read address.
- rd_data_o  output  width_p  registered read data, one-cycle latency.
- wr_count_o  output  $clog2(depth_p+1)  number of words accepted since the last start.
- busy_o  output  1  high in CLEAR or LOAD.
- done_o  output  1  high in DONE.

## Operation
- States: IDLE, CLEAR, LOAD, DONE.
- A transfer occurs when valid_i && ready_o are both high in the same cycle.
- ready_o = (state == LOAD) && !start_i. ready_o is low in every other case.
- IDLE: waits. start_i moves the FSM to CLEAR and resets the address counter to 0.
- CLEAR: writes zero to addr, addr+1, and so on, one word per cycle. After writing depth_p-1, the FSM moves to LOAD, with addr and wr_count_o reset to 0. CLEAR always takes exactly depth_p cycles.
- LOAD: each transfer writes data_i to addr, then increments addr and wr_count_o.
  - The FSM moves to DONE after a transfer with last_i=1, or after the transfer that writes address depth_p-1 (the RAM is full).
  - In the full case wr_count_o = depth_p and addr does not wrap.
- DONE: holds until start_i. Words offered in DONE are not accepted.
- start_i in CLEAR, LOAD or DONE restarts CLEAR from address 0 and zeroes wr_count_o. start_i has priority over a same-cycle beat; that beat is not written.
- Read port: rd_data_o <= mem[rd_addr_i] on every cycle, in every state.
  - Read and write to the same address in the same cycle returns the old contents.
  - The game only consumes data when done_o is high.
- reset_i does not clear RAM contents. Only the start sequence clears the RAM.

## Timing
- Reset values: state IDLE; ready_o, busy_o, done_o at 0; wr_count_o at 0; address counter at 0; rd_data_o at 0.
- reset_i asserted mid-CLEAR or mid-LOAD aborts immediately to IDLE. RAM is left partially written.
- Cycle after the start_i pulse: busy_o=1, ready_o=0.
- ready_o first rises depth_p cycles after the CLEAR state is entered.
- The write is visible on the read port one cycle after the transfer cycle; rd_data_o updates on the following edge.
- done_o rises on the cycle after the final transfer. busy_o falls on that same cycle.
- Throughput: one word per cycle in LOAD; no bubbles are inserted.

## Structure
- The shared package chart_pkg holds:
  - the state enum chart_wr_state_e (IDLE, CLEAR, LOAD, DONE);
  - any common chart word constants also used by the ROM and scheduler.
- Sub-module ram_1r1w_sync (width_p, depth_p):
  - one synchronous write port and one registered read port;
  - inferable as iCE40 block RAM;
  - output register reset by reset_i.
- chart_writer holds the FSM, the address counter, wr_count_o and the write-mux logic (zero in CLEAR, data_i in LOAD).

## Test plan
- Reset, then idle 10 cycles -> ready_o=0, busy_o=0, done_o=0, wr_count_o=0, rd_data_o=0.
- depth_p=128: start_i, then count cycles -> ready_o rises exactly 128 cycles later. Read all addresses -> all 0x00.
- Full 128-word load:
  - Send words 0x00..0x7F with last_i=0 throughout.
  - Required: done_o rises after word 127 and wr_count_o=128.
  - Required: reading address 37 gives 0x25 one cycle after rd_addr_i=37.
  - A 129th word offered is not accepted.
- Short chart over a previous full chart:
  - Load 3 words 0xA1, 0xB2, 0xC3, with last_i on 0xC3.
  - Required: wr_count_o=3, done_o=1, addresses 0..2 read 0xA1/0xB2/0xC3, addresses 3..127 read 0x00.
- Random valid_i gaps in LOAD -> the stored sequence is identical to the offered sequence and no word is duplicated or dropped.
- start_i mid-load:
  - After 5 words, pulse start_i in the same cycle as valid_i with 0xEE.
  - Required: 0xEE is not written, wr_count_o=0, CLEAR restarts, and all addresses read 0 after CLEAR.
  - Repeat with reset_i instead of start_i -> FSM in IDLE next cycle and the 5 written words are still readable.

Source files
------------

// File: rtl/chart_pkg.sv
// Shared chart definitions: writer FSM state encoding and chart word constants
// common to the chart ROM, the writer and the note scheduler.
package chart_pkg;

  localparam int CHART_WORD_W = 8;
  localparam int CHART_DEPTH  = 128;

  // A zero word is a rest step; CLEAR fills the RAM with it.
  localparam logic [CHART_WORD_W-1:0] CHART_REST = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } chart_wr_state_e;

endpackage

// File: rtl/ram_1r1w_sync.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Read-during-write to the same address returns the old contents.
module ram_1r1w_sync #(
  parameter  int width_p = 8,
  parameter  int depth_p = 128,
  localparam int addr_w  = $clog2(depth_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               wr_en_i,
  input  logic [addr_w-1:0]  wr_addr_i,
  input  logic [width_p-1:0] wr_data_i,
  input  logic [addr_w-1:0]  rd_addr_i,
  output logic [width_p-1:0] rd_data_o
);

  logic [width_p-1:0] mem [depth_p];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  // Only the output register resets; array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) rd_data_o <= '0;
    else         rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/chart_writer.sv
// Loads a chart word stream into RAM after clearing it; game reads the RAM
// through a registered port.
//
// state | meaning
// IDLE  | waiting for start_i after reset
// CLEAR | writing zero to every address, one per cycle
// LOAD  | accepting words at addr, one per transfer
// DONE  | chart complete, RAM stable for the game
module chart_writer
  import chart_pkg::*;
#(
  parameter  int width_p = CHART_WORD_W,
  parameter  int depth_p = CHART_DEPTH,
  localparam int addr_w  = $clog2(depth_p),
  localparam int count_w = $clog2(depth_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  input  logic               last_i,
  output logic               ready_o,
  input  logic [addr_w-1:0]  rd_addr_i,
  output logic [width_p-1:0] rd_data_o,
  output logic [count_w-1:0] wr_count_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [addr_w-1:0] addr_last = addr_w'(depth_p - 1);

  chart_wr_state_e   state_q, state_n;
  logic [addr_w-1:0]  addr_q, addr_n;
  logic [count_w-1:0] count_q, count_n;
  logic               wr_en;
  logic [width_p-1:0] wr_data;
  logic               xfer;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
      count_q <= count_n;
    end
  end

  assign xfer = valid_i && ready_o;

  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    count_n = count_q;
    ready_o = 1'b0;
    wr_en   = 1'b0;
    wr_data = CHART_REST;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_n = CLEAR;
          addr_n  = '0;
          count_n = '0;
        end
      end
      CLEAR: begin
        wr_en = 1'b1;
        if (start_i) begin
          addr_n  = '0;
          count_n = '0;
        end else if (addr_q == addr_last) begin
          state_n = LOAD;
          addr_n  = '0;
          count_n = '0;
        end else begin
          addr_n = addr_q + addr_w'(1);
        end
      end
      LOAD: begin
        ready_o = !start_i;
        wr_data = data_i;
        if (start_i) begin
          state_n = CLEAR;
          addr_n  = '0;
          count_n = '0;
        end else if (xfer) begin
          wr_en   = 1'b1;
          count_n = count_q + count_w'(1);
          // Full RAM ends the chart too; addr parks at the last slot.
          if (last_i || addr_q == addr_last) state_n = DONE;
          else                               addr_n  = addr_q + addr_w'(1);
        end
      end
      DONE: begin
        if (start_i) begin
          state_n = CLEAR;
          addr_n  = '0;
          count_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    // A reset aborts the cycle outright, including any in-flight write.
    if (reset_i) wr_en = 1'b0;
  end

  ram_1r1w_sync #(
    .width_p(width_p),
    .depth_p(depth_p)
  ) u_ram (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .wr_en_i  (wr_en),
    .wr_addr_i(addr_q),
    .wr_data_i(wr_data),
    .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o)
  );

  assign wr_count_o = count_q;
  assign busy_o     = (state_q == CLEAR) || (state_q == LOAD);
  assign done_o     = (state_q == DONE);

endmodule

// File: tb/tb_chart_writer.sv
// Directed bench for chart_writer at width 8, depth 128.
module tb_chart_writer;
  localparam int W  = 8;
  localparam int D  = 128;
  localparam int AW = $clog2(D);
  localparam int CW = $clog2(D + 1);

  logic          clk_i = 1'b0;
  logic          reset_i, start_i, valid_i, last_i;
  logic [W-1:0]  data_i;
  logic          ready_o, busy_o, done_o;
  logic [AW-1:0] rd_addr_i;
  logic [W-1:0]  rd_data_o;
  logic [CW-1:0] wr_count_o;

  int n_assert = 0;
  int n_fail   = 0;

  chart_writer #(.width_p(W), .depth_p(D)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .last_i    (last_i),
    .ready_o   (ready_o),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o),
    .wr_count_o(wr_count_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready_o && n < 300) begin
      step();
      n++;
    end
  endtask

  task automatic read_word(input int a, output logic [W-1:0] d);
    rd_addr_i = AW'(a);
    step();
    d = rd_data_o;
  endtask

  task automatic check_range_zero(input string tag, input int lo, input int hi);
    logic [W-1:0] d;
    for (int a = lo; a <= hi; a++) begin
      read_word(a, d);
      check($sformatf("%s[%0d]", tag, a), 32'(d), 32'h0);
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic l);
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    step();
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  logic [W-1:0] rd;
  int           n;
  logic [W-1:0] gap_words [10];
  int           gap_len   [10];

  initial begin
    reset_i = 1'b1; start_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
    data_i = '0; rd_addr_i = '0;

    repeat (3) step();
    check("rst_rd_data", 32'(rd_data_o), 32'h0);
    check("rst_ready",   32'(ready_o),   32'h0);
    check("rst_count",   32'(wr_count_o), 32'h0);
    reset_i = 1'b0;
    repeat (10) step();
    check("idle_ready", 32'(ready_o),    32'h0);
    check("idle_busy",  32'(busy_o),     32'h0);
    check("idle_done",  32'(done_o),     32'h0);
    check("idle_count", 32'(wr_count_o), 32'h0);

    // Clear timing and contents.
    pulse_start();
    check("start_busy",  32'(busy_o),  32'h1);
    check("start_ready", 32'(ready_o), 32'h0);
    wait_ready(n);
    check("clear_cycles", 32'(n), 32'd128);
    check_range_zero("clear1", 0, D - 1);

    // Full 128-word load.
    check("load_ready0", 32'(ready_o), 32'h1);
    for (int i = 0; i < D; i++) begin
      if (i == D - 1) check("done_before_last", 32'(done_o), 32'h0);
      send(W'(i), 1'b0);
    end
    check("full_done",  32'(done_o),     32'h1);
    check("full_busy",  32'(busy_o),     32'h0);
    check("full_count", 32'(wr_count_o), 32'd128);
    valid_i = 1'b1; data_i = 8'h80;
    #1;
    check("full_129_ready", 32'(ready_o), 32'h0);
    step();
    valid_i = 1'b0;
    check("full_129_count", 32'(wr_count_o), 32'd128);
    read_word(37, rd);
    check("full_rd37", 32'(rd), 32'h25);
    read_word(127, rd);
    check("full_rd127", 32'(rd), 32'h7f);
    read_word(0, rd);
    check("full_rd0", 32'(rd), 32'h00);

    // Short chart over the full one.
    pulse_start();
    wait_ready(n);
    check("short_clear_cycles", 32'(n), 32'd128);
    send(8'hA1, 1'b0);
    send(8'hB2, 1'b0);
    send(8'hC3, 1'b1);
    check("short_count", 32'(wr_count_o), 32'd3);
    check("short_done",  32'(done_o),     32'h1);
    read_word(0, rd); check("short_rd0", 32'(rd), 32'hA1);
    read_word(1, rd); check("short_rd1", 32'(rd), 32'hB2);
    read_word(2, rd); check("short_rd2", 32'(rd), 32'hC3);
    check_range_zero("short_tail", 3, D - 1);

    // Load with valid gaps between words.
    gap_words = '{8'h13, 8'h24, 8'h35, 8'h46, 8'h57, 8'h68, 8'h79, 8'h8A, 8'h9B, 8'hAC};
    gap_len   = '{0, 2, 0, 1, 3, 0, 0, 4, 1, 2};
    pulse_start();
    wait_ready(n);
    check("gap_clear_cycles", 32'(n), 32'd128);
    for (int k = 0; k < 10; k++) begin
      repeat (gap_len[k]) step();
      send(gap_words[k], k == 9);
    end
    check("gap_count", 32'(wr_count_o), 32'd10);
    check("gap_done",  32'(done_o),     32'h1);
    for (int k = 0; k < 10; k++) begin
      read_word(k, rd);
      check($sformatf("gap_rd%0d", k), 32'(rd), 32'(gap_words[k]));
    end
    read_word(10, rd);
    check("gap_rd10", 32'(rd), 32'h0);

    // start_i colliding with a beat after 5 words.
    pulse_start();
    wait_ready(n);
    for (int k = 0; k < 5; k++) send(W'(8'h51 + k), 1'b0);
    check("mid_count5", 32'(wr_count_o), 32'd5);
    valid_i = 1'b1; data_i = 8'hEE; start_i = 1'b1;
    #1;
    check("mid_start_ready", 32'(ready_o), 32'h0);
    step();
    valid_i = 1'b0; start_i = 1'b0;
    check("mid_count0", 32'(wr_count_o), 32'd0);
    check("mid_busy",   32'(busy_o),     32'h1);
    check("mid_done",   32'(done_o),     32'h0);
    wait_ready(n);
    check("mid_clear_cycles", 32'(n), 32'd128);
    check_range_zero("mid_clear", 0, D - 1);

    // reset_i colliding with a beat after 5 words.
    for (int k = 0; k < 5; k++) send(W'(8'h61 + k), 1'b0);
    valid_i = 1'b1; data_i = 8'hEE; reset_i = 1'b1;
    step();
    valid_i = 1'b0; reset_i = 1'b0;
    check("rst_mid_busy",  32'(busy_o),     32'h0);
    check("rst_mid_done",  32'(done_o),     32'h0);
    check("rst_mid_ready", 32'(ready_o),    32'h0);
    check("rst_mid_count", 32'(wr_count_o), 32'd0);
    for (int k = 0; k < 5; k++) begin
      read_word(k, rd);
      check($sformatf("rst_mid_rd%0d", k), 32'(rd), 32'(8'h61 + k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
